// File: rtl/ejtag_imatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ejtag_imatch_pkg : shared constants for the EJTAG instruction breakpoint   |
// |   unit (register offsets, IBC bit positions, channel limit).               |
// |   Optional feature macro: EJTAG_IBRK_ASID_EN                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ejtag_imatch_pkg;

  typedef enum logic [1:0] {
    REG_IBA   = 2'b00,
    REG_IBC   = 2'b01,
    REG_IBM   = 2'b10,
    REG_IBCNT = 2'b11
  } ibrk_reg_e;

  localparam int IBC_BE      = 0;
  localparam int IBC_TE      = 2;
  localparam int IBC_CNTE    = 3;
`ifdef EJTAG_IBRK_ASID_EN
  localparam int IBC_ASIDUSE  = 23;
  localparam int IBC_ASID_LSB = 24;
`endif

  localparam int NIBRK_MAX   = 15;
  localparam int IBS_NUM_LSB = 24;

endpackage

`default_nettype wire

// File: rtl/ejtag_imatch_cnt_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ejtag_imatch_cnt_if : drseg access bus plus fetch/CP0 hit signals for the  |
// |   instruction breakpoint unit. Optional macro: EJTAG_IBRK_ASID_EN          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ejtag_imatch_cnt_if;

  logic [31:0] EJDI_DATA;
  logic [7:2]  EJDI_ADDR;
  logic        EJDI_RW;
  logic        EJ_STROBE;
  logic        EJDI_SELIBS;
  logic        EJDI_SELIBRS;
  logic        LW_ISAMPLE_S;
  logic [31:0] LW_IADDR_S_R;
  logic        PBI_EJHOLD;
  logic        CP0_JCTRLDM_I_R;
  logic        CP0_DIBIFNOTDMBH_M_P;
`ifdef EJTAG_IBRK_ASID_EN
  logic [7:0]  CP0_ASID;
`endif
  logic [31:0] EJIM_DATA;
  logic        EJIM_BREAKHIT;
  logic        EJIM_TRACEHIT;

  modport master (
`ifdef EJTAG_IBRK_ASID_EN
    output CP0_ASID,
`endif
    output EJDI_DATA, EJDI_ADDR, EJDI_RW, EJ_STROBE, EJDI_SELIBS, EJDI_SELIBRS,
    output LW_ISAMPLE_S, LW_IADDR_S_R, PBI_EJHOLD, CP0_JCTRLDM_I_R, CP0_DIBIFNOTDMBH_M_P,
    input  EJIM_DATA, EJIM_BREAKHIT, EJIM_TRACEHIT
  );

  modport slave (
`ifdef EJTAG_IBRK_ASID_EN
    input  CP0_ASID,
`endif
    input  EJDI_DATA, EJDI_ADDR, EJDI_RW, EJ_STROBE, EJDI_SELIBS, EJDI_SELIBRS,
    input  LW_ISAMPLE_S, LW_IADDR_S_R, PBI_EJHOLD, CP0_JCTRLDM_I_R, CP0_DIBIFNOTDMBH_M_P,
    output EJIM_DATA, EJIM_BREAKHIT, EJIM_TRACEHIT
  );

endinterface

`default_nettype wire

// File: rtl/ejtag_ibrk_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ejtag_ibrk_chan : one instruction breakpoint channel - IBA/IBC/IBM/IBCNT   |
// |   registers, masked address compare and pass counter.                      |
// |   Optional macro: EJTAG_IBRK_ASID_EN                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ejtag_ibrk_chan
  import ejtag_imatch_pkg::*;
#(
  parameter int PASS_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  ibrk_reg_e   ofs_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        sample_i,
  input  logic [31:0] iaddr_i,
  input  logic        hold_i,
  input  logic        dm_i,
`ifdef EJTAG_IBRK_ASID_EN
  input  logic [7:0]  asid_i,
`endif
  output logic        hit_o,
  output logic        trace_o
);

  logic [31:1]       iba_q;
  logic [31:1]       ibm_q;
  logic              be_q;
  logic              te_q;
  logic              cnte_q;
  logic [PASS_W-1:0] reload_q;
  logic [PASS_W-1:0] cnt_q;
  logic [PASS_W-1:0] cnt_d;
  logic              w_raw;
  logic              w_cnt_zero;
  logic              w_asid_ok;
  logic              w_unused_wd;

  assign w_unused_wd = wdata_i[1];

`ifdef EJTAG_IBRK_ASID_EN
  logic       asiduse_q;
  logic [7:0] asid_q;
  assign w_asid_ok = ~asiduse_q | (asid_q == asid_i);
`else
  assign w_asid_ok = 1'b1;
`endif

  // IBM bit set = don't care; bit 0 of the fetch address never participates
  assign w_raw      = sample_i & w_asid_ok & (&((iaddr_i ~^ {iba_q, 1'b0}) | {ibm_q, 1'b1}));
  assign w_cnt_zero = (cnt_q == '0);
  assign hit_o      = be_q & w_raw & (~cnte_q | w_cnt_zero);
  assign trace_o    = te_q & w_raw;

  always_comb begin
    cnt_d = cnt_q;
    if (we_i && (ofs_i == REG_IBCNT)) begin
      cnt_d = wdata_i[PASS_W-1:0];
    end else if (~hold_i & ~dm_i & be_q & cnte_q & w_raw) begin
      cnt_d = w_cnt_zero ? reload_q : (cnt_q - PASS_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iba_q     <= '0;
      ibm_q     <= '0;
      be_q      <= 1'b0;
      te_q      <= 1'b0;
      cnte_q    <= 1'b0;
      reload_q  <= '0;
      cnt_q     <= '0;
`ifdef EJTAG_IBRK_ASID_EN
      asiduse_q <= 1'b0;
      asid_q    <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (we_i) begin
        case (ofs_i)
          REG_IBA:   iba_q <= wdata_i[31:1];
          REG_IBM:   ibm_q <= wdata_i[31:1];
          REG_IBCNT: reload_q <= wdata_i[PASS_W-1:0];
          REG_IBC: begin
            be_q      <= wdata_i[IBC_BE];
            te_q      <= wdata_i[IBC_TE];
            cnte_q    <= wdata_i[IBC_CNTE];
`ifdef EJTAG_IBRK_ASID_EN
            asiduse_q <= wdata_i[IBC_ASIDUSE];
            asid_q    <= wdata_i[IBC_ASID_LSB +: 8];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (ofs_i)
      REG_IBA:   rdata_o = {iba_q, 1'b0};
      REG_IBM:   rdata_o = {ibm_q, 1'b0};
      REG_IBCNT: rdata_o[PASS_W-1:0] = cnt_q;
      REG_IBC: begin
        rdata_o[IBC_BE]   = be_q;
        rdata_o[IBC_TE]   = te_q;
        rdata_o[IBC_CNTE] = cnte_q;
`ifdef EJTAG_IBRK_ASID_EN
        rdata_o[IBC_ASIDUSE]       = asiduse_q;
        rdata_o[IBC_ASID_LSB +: 8] = asid_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ejtag_imatch_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ejtag_imatch_cnt : EJTAG instruction breakpoint unit with NIBRK counted    |
// |   channels, drseg decode/read mux, S->E->M hit pipeline and sticky IBS.    |
// |   Optional macro: EJTAG_IBRK_ASID_EN                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ejtag_imatch_cnt
  import ejtag_imatch_pkg::*;
#(
  parameter int NIBRK  = 4,
  parameter int PASS_W = 16
) (
  input  logic              CORE_CLOCK,
  input  logic              RESET_D1_R,
  ejtag_imatch_cnt_if.slave ejdi_io
);

  localparam int c_nch = (NIBRK > NIBRK_MAX) ? NIBRK_MAX : ((NIBRK < 1) ? 1 : NIBRK);

  logic [3:0]       w_idx;
  ibrk_reg_e        w_ofs;
  logic             w_wr;
  logic [c_nch-1:0] w_hit_s;
  logic [c_nch-1:0] w_trace_s;
  logic [c_nch-1:0] w_hit_m;
  logic [c_nch-1:0] w_clr;
  logic [c_nch-1:0] pend_q;
  logic [c_nch-1:0] hit_e_q;
  logic [c_nch-1:0] status_q;
  logic [31:0]      w_chan_rd [c_nch];
  logic [31:0]      w_ibs;
  logic [31:0]      w_rdata;

  assign w_idx = ejdi_io.EJDI_ADDR[7:4];
  assign w_ofs = ibrk_reg_e'(ejdi_io.EJDI_ADDR[3:2]);
  assign w_wr  = ejdi_io.EJ_STROBE & ~ejdi_io.EJDI_RW;

  for (genvar gi = 0; gi < c_nch; gi++) begin : g_chan
    ejtag_ibrk_chan #(
      .PASS_W (PASS_W)
    ) u_chan (
      .clk      (CORE_CLOCK),
      .rst      (RESET_D1_R),
      .we_i     (w_wr & ejdi_io.EJDI_SELIBRS & (w_idx == 4'(gi))),
      .ofs_i    (w_ofs),
      .wdata_i  (ejdi_io.EJDI_DATA),
      .rdata_o  (w_chan_rd[gi]),
      .sample_i (ejdi_io.LW_ISAMPLE_S),
      .iaddr_i  (ejdi_io.LW_IADDR_S_R),
      .hold_i   (ejdi_io.PBI_EJHOLD),
      .dm_i     (ejdi_io.CP0_JCTRLDM_I_R),
`ifdef EJTAG_IBRK_ASID_EN
      .asid_i   (ejdi_io.CP0_ASID),
`endif
      .hit_o    (w_hit_s[gi]),
      .trace_o  (w_trace_s[gi])
    );
  end

  assign ejdi_io.EJIM_BREAKHIT = |w_hit_s;
  assign ejdi_io.EJIM_TRACEHIT = |w_trace_s;

  // M-stage hit is the E-stage register qualified by the M-stage exception,
  // so an S hit reaches IBS on the second clock edge
  assign w_hit_m = ejdi_io.CP0_DIBIFNOTDMBH_M_P ? hit_e_q : '0;
  assign w_clr   = (w_wr & ejdi_io.EJDI_SELIBS) ? ejdi_io.EJDI_DATA[c_nch-1:0] : '0;

  always_ff @(posedge CORE_CLOCK) begin
    if (RESET_D1_R) begin
      pend_q   <= '0;
      hit_e_q  <= '0;
      status_q <= '0;
    end else begin
      if (ejdi_io.PBI_EJHOLD & ~ejdi_io.CP0_JCTRLDM_I_R) begin
        pend_q <= pend_q | w_hit_s;
      end else begin
        pend_q <= '0;
      end
      if (~ejdi_io.PBI_EJHOLD) begin
        hit_e_q <= w_hit_s | pend_q;
      end
      status_q <= (status_q & ~w_clr) | w_hit_m;
    end
  end

  always_comb begin
    w_ibs                      = '0;
    w_ibs[IBS_NUM_LSB +: 4]    = 4'(c_nch);
    w_ibs[c_nch-1:0]           = status_q;
  end

  always_comb begin
    w_rdata = w_ibs;
    if (ejdi_io.EJDI_SELIBRS) begin
      w_rdata = '0;
      for (int i = 0; i < c_nch; i++) begin
        if (w_idx == 4'(i)) begin
          w_rdata = w_chan_rd[i];
        end
      end
    end
  end

  assign ejdi_io.EJIM_DATA = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ejtag_imatch_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ejtag_imatch_cnt : directed scenarios plus randomized traffic checked   |
// |   against a behavioural model of the breakpoint unit.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ejtag_imatch_cnt;

  localparam logic [31:0] BP_ADDR = 32'h8000_1000;
  localparam logic [31:0] IBS_ID  = 32'h0400_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ejtag_imatch_cnt_if u_if ();

  ejtag_imatch_cnt #(
    .NIBRK  (4),
    .PASS_W (16)
  ) dut (
    .CORE_CLOCK (clk),
    .RESET_D1_R (rst),
    .ejdi_io    (u_if.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_iba [4];
  logic [31:0] m_ibm [4];
  logic [31:0] m_ibc [4];
  int unsigned m_rel [4];
  int unsigned m_cnt [4];
  logic [3:0]  m_pend;
  logic [3:0]  m_e;
  logic [3:0]  m_status;

  logic [31:0] iba_tab [4] = '{32'h8000_1000, 32'h8000_1040, 32'h8000_2000, 32'h8000_10F0};
  logic [31:0] ibm_tab [4] = '{32'h0, 32'h0000_00FC, 32'h0000_00F0, 32'h0000_FFF0};
  logic [31:0] adr_tab [5] = '{32'h8000_1000, 32'h8000_1004, 32'h8000_10F4, 32'h8000_2000, 32'h8000_2011};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      m_iba[c] = 0; m_ibm[c] = 0; m_ibc[c] = 0; m_rel[c] = 0; m_cnt[c] = 0;
    end
    m_pend = 0; m_e = 0; m_status = 0;
  endtask

  function automatic logic m_raw(input int c);
    return u_if.LW_ISAMPLE_S &&
           (((u_if.LW_IADDR_S_R ^ m_iba[c]) & ~m_ibm[c] & 32'hFFFF_FFFE) == 32'h0);
  endfunction

  function automatic logic m_qual(input int c);
    return m_ibc[c][0] && m_raw(c) && (!m_ibc[c][3] || m_cnt[c] == 0);
  endfunction

  function automatic logic [31:0] m_read();
    int c;
    c = int'(u_if.EJDI_ADDR[7:4]);
    if (!u_if.EJDI_SELIBRS) return IBS_ID | 32'(m_status);
    if (c >= 4) return 32'h0;
    case (u_if.EJDI_ADDR[3:2])
      2'd0:    return m_iba[c];
      2'd1:    return m_ibc[c];
      2'd2:    return m_ibm[c];
      default: return m_cnt[c];
    endcase
  endfunction

  // Compare combinational outputs, advance the model across one edge, return at the next negedge
  task automatic step();
    logic [3:0] hit;
    logic [3:0] clr;
    logic       trc;
    logic       wr;
    logic       cnt_wr;
    int         wc;
    int         ofs;
    #1;
    hit = 0;
    trc = 0;
    for (int c = 0; c < 4; c++) begin
      hit[c] = m_qual(c);
      trc    = trc | (m_raw(c) & m_ibc[c][2]);
    end
    check_val("breakhit", 32'(u_if.EJIM_BREAKHIT), 32'(|hit));
    check_val("tracehit", 32'(u_if.EJIM_TRACEHIT), 32'(trc));
    check_val("rdata", u_if.EJIM_DATA, m_read());
    if (rst) begin
      m_reset();
    end else begin
      wr  = u_if.EJ_STROBE && !u_if.EJDI_RW;
      wc  = int'(u_if.EJDI_ADDR[7:4]);
      ofs = int'(u_if.EJDI_ADDR[3:2]);
      for (int c = 0; c < 4; c++) begin
        cnt_wr = wr && u_if.EJDI_SELIBRS && wc == c && ofs == 3;
        if (!cnt_wr && !u_if.PBI_EJHOLD && !u_if.CP0_JCTRLDM_I_R &&
            m_ibc[c][0] && m_ibc[c][3] && m_raw(c))
          m_cnt[c] = (m_cnt[c] == 0) ? m_rel[c] : m_cnt[c] - 1;
      end
      clr      = (wr && u_if.EJDI_SELIBS) ? u_if.EJDI_DATA[3:0] : 4'h0;
      m_status = (m_status & ~clr) | (u_if.CP0_DIBIFNOTDMBH_M_P ? m_e : 4'h0);
      if (!u_if.PBI_EJHOLD) m_e = hit | m_pend;
      m_pend = (u_if.PBI_EJHOLD && !u_if.CP0_JCTRLDM_I_R) ? (m_pend | hit) : 4'h0;
      if (wr && u_if.EJDI_SELIBRS && wc < 4) begin
        case (ofs)
          0: m_iba[wc] = u_if.EJDI_DATA & 32'hFFFF_FFFE;
          1: m_ibc[wc] = u_if.EJDI_DATA & 32'h0000_000D;
          2: m_ibm[wc] = u_if.EJDI_DATA & 32'hFFFF_FFFE;
          default: begin
            m_rel[wc] = 32'(u_if.EJDI_DATA[15:0]);
            m_cnt[wc] = 32'(u_if.EJDI_DATA[15:0]);
          end
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input int ch, input int ofs, input logic [31:0] d);
    u_if.EJ_STROBE = 1; u_if.EJDI_RW = 0; u_if.EJDI_SELIBS = 0; u_if.EJDI_SELIBRS = 1;
    u_if.EJDI_ADDR = {4'(ch), 2'(ofs)}; u_if.EJDI_DATA = d;
    step();
    u_if.EJ_STROBE = 0; u_if.EJDI_RW = 1;
  endtask

  task automatic wr_ibs(input logic [31:0] d);
    u_if.EJ_STROBE = 1; u_if.EJDI_RW = 0; u_if.EJDI_SELIBS = 1; u_if.EJDI_SELIBRS = 0;
    u_if.EJDI_DATA = d;
    step();
    u_if.EJ_STROBE = 0; u_if.EJDI_RW = 1;
  endtask

  task automatic sel_reg(input int ch, input int ofs);
    u_if.EJDI_SELIBS = 0; u_if.EJDI_SELIBRS = 1; u_if.EJDI_ADDR = {4'(ch), 2'(ofs)};
  endtask

  task automatic sel_ibs();
    u_if.EJDI_SELIBS = 1; u_if.EJDI_SELIBRS = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    u_if.LW_ISAMPLE_S = 1; u_if.LW_IADDR_S_R = a;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    u_if.EJDI_DATA = 0; u_if.EJDI_ADDR = 0; u_if.EJDI_RW = 1; u_if.EJ_STROBE = 0;
    u_if.EJDI_SELIBS = 1; u_if.EJDI_SELIBRS = 0;
    u_if.LW_ISAMPLE_S = 0; u_if.LW_IADDR_S_R = 0; u_if.PBI_EJHOLD = 0;
    u_if.CP0_JCTRLDM_I_R = 0; u_if.CP0_DIBIFNOTDMBH_M_P = 1;
`ifdef EJTAG_IBRK_ASID_EN
    u_if.CP0_ASID = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_reset();
    rst = 0;

    #1;
    check_val("rst_ibs", u_if.EJIM_DATA, IBS_ID);
    check_val("rst_brk", 32'(u_if.EJIM_BREAKHIT), 32'h0);
    sel_reg(0, 3);
    #1 check_val("rst_cnt", u_if.EJIM_DATA, 32'h0);

    // basic exact-match breakpoint and IBS latency
    wr_reg(0, 0, BP_ADDR); wr_reg(0, 2, 32'h0); wr_reg(0, 1, 32'h1);
    sel_ibs(); fetch(BP_ADDR);
    #1 check_val("bp_same_cycle", 32'(u_if.EJIM_BREAKHIT), 32'h1);
    step(); u_if.LW_ISAMPLE_S = 0;
    #1 check_val("ibs_one_edge", u_if.EJIM_DATA, IBS_ID);
    step();
    #1 check_val("ibs_two_edges", u_if.EJIM_DATA, IBS_ID | 32'h1);
    wr_ibs(32'h1);
    #1 check_val("w1c_alone", u_if.EJIM_DATA, IBS_ID);

    // masked compare
    wr_reg(0, 2, 32'h0000_00FC);
    fetch(32'h8000_10F4);
    #1 check_val("mask_hit", 32'(u_if.EJIM_BREAKHIT), 32'h1);
    step(); fetch(32'h8000_1100);
    #1 check_val("mask_miss", 32'(u_if.EJIM_BREAKHIT), 32'h0);
    step(); u_if.LW_ISAMPLE_S = 0;
    wr_ibs(32'hF);

    // pass counter
    wr_reg(0, 2, 32'h0); wr_reg(0, 3, 32'd3); wr_reg(0, 1, 32'h9);
    for (int k = 0; k < 3; k++) begin
      fetch(BP_ADDR);
      #1 check_val("cnt_nobrk", 32'(u_if.EJIM_BREAKHIT), 32'h0);
      step(); u_if.LW_ISAMPLE_S = 0; sel_reg(0, 3);
      #1 check_val("cnt_value", u_if.EJIM_DATA, 32'(2 - k));
    end
    fetch(BP_ADDR);
    #1 check_val("cnt_brk", 32'(u_if.EJIM_BREAKHIT), 32'h1);
    step(); u_if.LW_ISAMPLE_S = 0;
    #1 check_val("cnt_reload", u_if.EJIM_DATA, 32'd3);
    step(); wr_ibs(32'hF);

    // hit under pipeline hold
    wr_reg(0, 1, 32'h1); sel_ibs();
    u_if.PBI_EJHOLD = 1; fetch(BP_ADDR);
    step(); u_if.LW_ISAMPLE_S = 0; step(); step();
    #1 check_val("hold_no_status", u_if.EJIM_DATA, IBS_ID);
    u_if.PBI_EJHOLD = 0;
    step();
    #1 check_val("hold_release_e", u_if.EJIM_DATA, IBS_ID);
    step();
    #1 check_val("hold_release_ibs", u_if.EJIM_DATA, IBS_ID | 32'h1);

    // W1C colliding with M-stage hit
    wr_ibs(32'h1);
    fetch(BP_ADDR); step(); u_if.LW_ISAMPLE_S = 0;
    wr_ibs(32'h1);
    #1 check_val("w1c_vs_hit", u_if.EJIM_DATA, IBS_ID | 32'h1);
    wr_ibs(32'h1);
    #1 check_val("w1c_clear", u_if.EJIM_DATA, IBS_ID);

    // out-of-range channel and IBC readback masking
    wr_reg(5, 0, 32'hFFFF_FFFF); sel_reg(5, 0);
    #1 check_val("oor_read", u_if.EJIM_DATA, 32'h0);
    sel_reg(0, 0);
    #1 check_val("iba_kept", u_if.EJIM_DATA, BP_ADDR);
    wr_reg(0, 1, 32'hFFFF_FFF7); sel_reg(0, 1);
    #1 check_val("ibc_mask", u_if.EJIM_DATA, 32'h5);
    fetch(BP_ADDR);
    #1 check_val("trace_hit", 32'(u_if.EJIM_TRACEHIT), 32'h1);
    step(); u_if.LW_ISAMPLE_S = 0;

    // reset in the middle of a count
    wr_reg(0, 1, 32'h9); wr_reg(0, 3, 32'd3);
    fetch(BP_ADDR); step(); u_if.LW_ISAMPLE_S = 0; sel_reg(0, 3);
    #1 check_val("pre_rst_cnt", u_if.EJIM_DATA, 32'd2);
    rst = 1; fetch(BP_ADDR); step(); rst = 0;
    #1 check_val("post_rst_brk", 32'(u_if.EJIM_BREAKHIT), 32'h0);
    check_val("post_rst_cnt", u_if.EJIM_DATA, 32'h0);
    sel_reg(0, 0);
    #1 check_val("post_rst_iba", u_if.EJIM_DATA, 32'h0);
    u_if.LW_ISAMPLE_S = 0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 299) == 0);
      u_if.EJ_STROBE = ($urandom_range(0, 99) < 35);
      u_if.EJDI_RW   = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 3);
      u_if.EJDI_SELIBS  = (r == 0);
      u_if.EJDI_SELIBRS = (r >= 2);
      u_if.EJDI_ADDR = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      if (u_if.EJDI_SELIBS) begin
        u_if.EJDI_DATA = $urandom;
      end else begin
        case (u_if.EJDI_ADDR[3:2])
          2'd0:    u_if.EJDI_DATA = iba_tab[$urandom_range(0, 3)];
          2'd1:    u_if.EJDI_DATA = $urandom | 32'($urandom_range(0, 3) != 0);
          2'd2:    u_if.EJDI_DATA = ibm_tab[$urandom_range(0, 3)];
          default: u_if.EJDI_DATA = 32'($urandom_range(0, 3));
        endcase
      end
      u_if.LW_ISAMPLE_S = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 5);
      u_if.LW_IADDR_S_R = (r < 5) ? adr_tab[r] : $urandom;
      u_if.PBI_EJHOLD           = ($urandom_range(0, 4) == 0);
      u_if.CP0_JCTRLDM_I_R      = ($urandom_range(0, 9) == 0);
      u_if.CP0_DIBIFNOTDMBH_M_P = ($urandom_range(0, 19) < 17);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
